// File: rtl/quad_decoder_if.sv
// Quadrature decoder port bundle: phase inputs and controls in, position and status out.
interface quad_decoder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             a_in;
    logic             b_in;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] pos;
    logic             step;
    logic             dir;
    logic             wrap;
    logic             err;

    modport master (
        output a_in, b_in, en, clr,
        input  pos, step, dir, wrap, err
    );

    modport slave (
        input  a_in, b_in, en, clr,
        output pos, step, dir, wrap, err
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and debounces A/B phases, then counts
// Gray-code steps into a wrapping position register with direction and error status.
module quad_decoder #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FILT_CYC = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    quad_decoder_if.slave bus
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SET_W = 5;
    localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(FILT_CYC - 1);
    // Longer than the sync + filter delay, so a level present at reset release loads first.
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(FILT_CYC + 3);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    logic [1:0]       sync1_q, sync2_q, filt_q, cur_q;
    logic [CNT_W-1:0] cnt_q [2];

    state_t           state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    // Per-channel 2-flop synchronizer and persistence filter; bit 1 = A, bit 0 = B.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q <= {bus.a_in, bus.b_in};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == FILT_LAST) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Decoder: INIT waits for the first filtered state, RUN counts steps.
    always_comb begin
        logic [1:0] chg;
        logic       up;
        state_d  = state_q;
        settle_d = settle_q;
        pos_d    = pos_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        err_d    = err_q;
        chg      = filt_q ^ cur_q;
        up       = filt_q[1] ^ cur_q[0];

        case (state_q)
            ST_INIT: begin
                if ((chg != 2'b00) || (settle_q == SETTLE_LAST)) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_RUN: begin
                if (chg == 2'b11) begin
                    err_d = 1'b1;
                end else if ((chg != 2'b00) && bus.en) begin
                    step_d = 1'b1;
                    dir_d  = up;
                    if (up) begin
                        pos_d  = pos_q + WIDTH'(1);
                        wrap_d = (pos_q == {WIDTH{1'b1}});
                    end else begin
                        pos_d  = pos_q - WIDTH'(1);
                        wrap_d = (pos_q == '0);
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (bus.clr) begin
            pos_d  = '0;
            err_d  = 1'b0;
            step_d = 1'b0;
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            settle_q <= '0;
            cur_q    <= '0;
            pos_q    <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cur_q    <= filt_q;
            pos_q    <= pos_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    assign bus.pos  = pos_q;
    assign bus.step = step_q;
    assign bus.dir  = dir_q;
    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: a phase-level model pushes expected
// outcomes onto a scoreboard that is popped when the step is due.
module tb_quad_decoder;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned FILT_CYC = 3;
    localparam int unsigned LAT      = FILT_CYC + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    quad_decoder_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder #(.WIDTH(WIDTH), .FILT_CYC(FILT_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic             step;
        logic [WIDTH-1:0] pos;
        logic             dir;
        logic             wrap;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [WIDTH-1:0] m_pos;
    logic             m_dir, m_err, m_en;
    logic [1:0]       m_ab;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        bus.a_in = ab[1];
        bus.b_in = ab[0];
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pos"}, 32'(bus.pos), 32'(m_pos));
        check({tag, ".dir"}, 32'(bus.dir), 32'(m_dir));
        check({tag, ".err"}, 32'(bus.err), 32'(m_err));
    endtask

    task automatic do_reset(input logic [1:0] ab, input int edges);
        logic seen;
        drive_ab(ab);
        rst_n = 1'b0;
        tick(edges);
        rst_n = 1'b1;
        m_pos = '0; m_dir = 1'b0; m_err = 1'b0; m_ab = ab;
        check("rst.pos",  32'(bus.pos),  32'd0);
        check("rst.step", 32'(bus.step), 32'd0);
        check("rst.dir",  32'(bus.dir),  32'd0);
        check("rst.wrap", 32'(bus.wrap), 32'd0);
        check("rst.err",  32'(bus.err),  32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen = seen | bus.step | bus.wrap | bus.err;
        end
        check("init.quiet", 32'(seen), 32'd0);
        check_state("init");
    endtask

    // Drive a new phase level, predict the outcome, and compare when the step is due.
    task automatic move(input string tag, input logic [1:0] ab);
        exp_t       e;
        logic [1:0] diff;
        logic       up;
        diff = ab ^ m_ab;
        up   = ab[1] ^ m_ab[0];
        e.step = 1'b0;
        e.wrap = 1'b0;
        if (diff == 2'b11) begin
            m_err = 1'b1;
        end else if (diff != 2'b00 && m_en) begin
            e.step = 1'b1;
            e.wrap = up ? (m_pos == {WIDTH{1'b1}}) : (m_pos == '0);
            m_pos  = up ? m_pos + WIDTH'(1) : m_pos - WIDTH'(1);
            m_dir  = up;
        end
        m_ab  = ab;
        e.pos = m_pos;
        e.dir = m_dir;
        e.err = m_err;
        sb.push_back(e);
        drive_ab(ab);

        tick(LAT - 1);
        check({tag, ".early"}, 32'(bus.step), 32'd0);
        tick(1);
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".step"}, 32'(bus.step), 32'(e.step));
            check({tag, ".pos"},  32'(bus.pos),  32'(e.pos));
            check({tag, ".dir"},  32'(bus.dir),  32'(e.dir));
            check({tag, ".wrap"}, 32'(bus.wrap), 32'(e.wrap));
            check({tag, ".err"},  32'(bus.err),  32'(e.err));
        end
        tick(1);
        check({tag, ".step_lo"}, 32'({bus.step, bus.wrap}), 32'd0);
        tick(1);
    endtask

    task automatic pulse_clr(input string tag);
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        m_pos = '0;
        m_err = 1'b0;
        check({tag, ".step"}, 32'({bus.step, bus.wrap}), 32'd0);
        check_state(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        bus.en   = 1'b1;
        bus.clr  = 1'b0;
        m_en     = 1'b1;
        @(posedge clk);
        #1;

        do_reset(2'b00, 2);

        move("up1", 2'b10);
        move("up2", 2'b11);
        move("up3", 2'b01);
        move("up4", 2'b00);
        check_state("fwd");

        pulse_clr("clr0");
        move("dn_wrap", 2'b01);
        move("up_wrap", 2'b00);

        // Glitch shorter than the filter window must be ignored.
        drive_ab(2'b10);
        tick(2);
        drive_ab(2'b00);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen = seen | bus.step | bus.wrap;
        end
        check("glitch.step", 32'(seen), 32'd0);
        check_state("glitch");

        move("illegal", 2'b11);
        pulse_clr("clr_err");

        bus.en = 1'b0;
        m_en   = 1'b0;
        move("dis1", 2'b01);
        move("dis2", 2'b00);
        move("dis3", 2'b10);
        bus.en = 1'b1;
        m_en   = 1'b1;
        move("en1", 2'b11);
        check_state("en");

        // Reset while a transition is partway through the filter.
        drive_ab(2'b01);
        tick(3);
        do_reset(2'b11, 1);
        move("post_rst", 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, which sets the position counter width.
REQ-002 The module SHALL have parameter FILT_CYC, default 3 (range 1..15), the number of consecutive cycles a synchronized phase must differ before it is accepted.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 a_in  input  1  phase A, asynchronous to clk.
REQ-006 b_in  input  1  phase B, asynchronous to clk.
REQ-007 en  input  1  count enable; 1 = position updates on valid steps.
REQ-008 clr  input  1  synchronous clear of pos and err.
REQ-009 pos  output  WIDTH  signed-agnostic position count, wraps modulo 2^WIDTH.
REQ-010 step  output  1  one-cycle pulse per counted step.
REQ-011 dir  output  1  direction of last valid transition; 1 = UP, 0 = DOWN.
REQ-012 wrap  output  1  one-cycle pulse when pos wraps (max->0 on UP, 0->max on DOWN).
REQ-013 err  output  1  sticky error flag: illegal phase transition seen.

Function
REQ-014 a_in and b_in SHALL each pass through a 2-flop synchronizer before any other logic.
REQ-015 Each channel SHALL have a filter: counter increments while the synchronized value differs from the filtered value and clears when they are equal; when the count reaches FILT_CYC, the filtered value takes the synchronized value and the counter clears.
REQ-016 The phase state {A_f,B_f} SHALL decode UP for 00->10->11->01->00 and DOWN for the reverse order.
REQ-017 A filtered change of exactly one bit SHALL be a valid step: if en=1 and clr=0, pos +/-1, step=1 for one cycle, dir updated, all registered one cycle after the filtered update.
REQ-018 Latency from an a_in/b_in edge (set up before edge 1) to step/pos update SHALL be exactly FILT_CYC+3 rising edges (FILT_CYC=3: at edge 6).
REQ-019 A filtered update changing both bits in the same cycle SHALL set err, SHALL NOT change pos, step or dir, and SHALL adopt the new state as current.
REQ-020 With en=0 the filtered state SHALL continue to track and err SHALL still be detected; pos, step, dir and wrap SHALL not change.
REQ-021 pos SHALL wrap modulo 2^WIDTH; wrap SHALL pulse in the same cycle as the wrapping step.
REQ-022 clr=1 SHALL set pos=0 and err=0 at the next edge, with priority over a coincident step; step and wrap SHALL be 0 that cycle; dir SHALL keep its value.
REQ-023 A glitch shorter than FILT_CYC synchronized cycles SHALL have no effect on any output.
REQ-024 step and wrap SHALL never be asserted for two consecutive cycles from one transition.

Reset
REQ-025 With rst_n=0 at a rising edge: synchronizers, filtered state and filter counters SHALL be cleared; pos=0, step=0, dir=0, wrap=0, err=0.
REQ-026 Reset asserted mid-movement SHALL discard any partially filtered transition.
REQ-027 The first filtered update after reset (one or both bits) SHALL be loaded as an initial state without step, count or err; decoding SHALL begin after that load.

Verification (WIDTH=4, FILT_CYC=3 unless noted)
REQ-028 Reset with inputs 00, then apply 00->10->11->01->00 with 8 cycles between changes -> four step pulses, first at edge 6 after the a_in edge, pos=4, dir=1, err=0.
REQ-029 From pos=0, apply one DOWN step (00->01) -> pos=15, wrap=1 for one cycle, dir=0.
REQ-030 Hold inputs 00, pulse a_in high for 2 cycles -> step, pos, err unchanged.
REQ-031 Toggle a_in and b_in together (00->11) -> err=1, pos unchanged, no step; then clr=1 one cycle -> pos=0, err=0.
REQ-032 en=0 during three UP steps, then en=1 and one more UP step -> pos increments by exactly 1, no err.
REQ-033 Assert rst_n=0 for one edge while a transition is in the filter, release with inputs at 11 -> all outputs 0, no step or err after the initial load of 11.
